alu_writeback: RTL

- Execute→writeback stage directly downstream of the 16-bit ALU.
- Captures each ALU result together with its operands, select code and destination, and computes Z/N/C/V status flags at capture time.
- Buffers up to DEPTH results in an in-order queue and drains them to the register-file write port under a valid/ready handshake.
- Commits flags only when the owning result retires, so a stalled register file never lets flags run ahead of architectural state.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/wb_flag_calc.sv | 54 +++++
 rtl/alu_writeback.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared CPU constants, ALU select codes and status-flag struct.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SHL  = 4'b0010;
    localparam logic [3:0] ALU_SHR  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SUB2 = 4'b0111;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

`default_nettype wire

// File: rtl/wb_flag_calc.sv
// ============================================================================
// Module  : wb_flag_calc
// Brief   : Combinational Z/N/C/V generator for a captured ALU result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_flag_calc #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] op0,
    input  logic [DATA_W-1:0] op1,
    input  logic [3:0]        select,
    output cpu_pkg::flags_t   flags,
    output logic              update_cv
);
    import cpu_pkg::*;

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] w_sum;
    logic            w_res_flip;

    assign w_sum      = {1'b0, op0} + {1'b0, op1};
    assign w_res_flip = (result[MSB] != op0[MSB]);

    always_comb begin
        flags.z   = (result == '0);
        flags.n   = result[MSB];
        flags.c   = 1'b0;
        flags.v   = 1'b0;
        update_cv = 1'b0;
        case (select)
            ALU_ADD: begin
                flags.c   = w_sum[DATA_W];
                flags.v   = (op0[MSB] == op1[MSB]) & w_res_flip;
                update_cv = 1'b1;
            end
            ALU_SUB, ALU_SUB2: begin
                // C is a borrow flag: set when the subtraction wraps.
                flags.c   = (op0 < op1);
                flags.v   = (op0[MSB] != op1[MSB]) & w_res_flip;
                update_cv = 1'b1;
            end
            default: begin
                update_cv = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_writeback.sv
// ============================================================================
// Module  : alu_writeback
// Brief   : ALU writeback stage: two-entry in-order queue to the register file
//           with flags committed at retire. Optional macro ALU_WB_FORWARD_EN
//           adds a forwarding view of the youngest pending register write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_writeback #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_op0,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [3:0]        in_select,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wb_en,
    output logic              rf_we,
    input  logic              rf_ready,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              busy
`ifdef ALU_WB_FORWARD_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);
    import cpu_pkg::*;

    localparam logic [1:0] C_DEPTH = 2'(DEPTH);

    // Queue storage; occupancy is tracked by r_count so data needs no reset.
    logic [DATA_W-1:0] r_res [2];
    logic [ADDR_W-1:0] r_dst [2];
    logic              r_wb  [2];
    flags_t            r_fl  [2];
    logic              r_ucv [2];

    logic [1:0]        r_count;
    logic              r_head;
    logic              r_tail;
    logic              r_in_ready;
    flags_t            r_flags;
    logic [ADDR_W-1:0] r_last_waddr;
    logic [DATA_W-1:0] r_last_wdata;

    flags_t            w_new_flags;
    logic              w_new_ucv;
    logic              w_head_valid;
    logic              w_rf_we;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count_nxt;

    wb_flag_calc #(
        .DATA_W    (DATA_W)
    ) u_flag_calc (
        .result    (in_result),
        .op0       (in_op0),
        .op1       (in_op1),
        .select    (in_select),
        .flags     (w_new_flags),
        .update_cv (w_new_ucv)
    );

    assign w_head_valid = (r_count != 2'd0);
    assign w_rf_we      = w_head_valid & r_wb[r_head];
    assign w_push       = in_valid & r_in_ready;
    // Flags-only entries retire as soon as they reach the head.
    assign w_pop        = w_head_valid & (r_wb[r_head] ? rf_ready : 1'b1);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= 2'd0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_flags      <= '0;
            r_last_waddr <= '0;
            r_last_wdata <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < C_DEPTH);
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head    <= ~r_head;
                r_flags.z <= r_fl[r_head].z;
                r_flags.n <= r_fl[r_head].n;
                if (r_ucv[r_head]) begin
                    r_flags.c <= r_fl[r_head].c;
                    r_flags.v <= r_fl[r_head].v;
                end
            end
            if (w_rf_we) begin
                r_last_waddr <= r_dst[r_head];
                r_last_wdata <= r_res[r_head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_res[r_tail] <= in_result;
            r_dst[r_tail] <= in_dest;
            r_wb[r_tail]  <= in_wb_en;
            r_fl[r_tail]  <= w_new_flags;
            r_ucv[r_tail] <= w_new_ucv;
        end
    end

    assign in_ready = r_in_ready;
    assign rf_we    = w_rf_we;
    assign rf_waddr = w_rf_we ? r_dst[r_head] : r_last_waddr;
    assign rf_wdata = w_rf_we ? r_res[r_head] : r_last_wdata;
    assign flag_z   = r_flags.z;
    assign flag_n   = r_flags.n;
    assign flag_c   = r_flags.c;
    assign flag_v   = r_flags.v;
    assign busy     = w_head_valid;

`ifdef ALU_WB_FORWARD_EN
    logic w_young;

    assign w_young = ~r_tail;

    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
        if (r_count != 2'd0 && r_wb[w_young]) begin
            fwd_valid = 1'b1;
            fwd_addr  = r_dst[w_young];
            fwd_data  = r_res[w_young];
        end else if (r_count == 2'd2 && r_wb[r_head]) begin
            fwd_valid = 1'b1;
            fwd_addr  = r_dst[r_head];
            fwd_data  = r_res[r_head];
        end
    end
`endif

endmodule

`default_nettype wire
